// File: rtl/onchip_mem_arbiter_pkg.sv
// Shared defaults and types for the two-port on-chip memory arbiter.
package onchip_mem_arbiter_pkg;

    localparam int DEPTH_DEFAULT  = 2560;
    localparam int ADDR_W_DEFAULT = 12;
    localparam int DATA_W_DEFAULT = 32;

    // Requester identity: P0 is the CPU, P1 is the DMA/video master.
    typedef enum logic {
        P0 = 1'b0,
        P1 = 1'b1
    } port_id_t;

    // One-deep read response record, captured in the grant cycle.
    typedef struct packed {
        logic     valid;
        port_id_t port;
        logic     oor;
    } rsp_t;

endpackage

// File: rtl/onchip_mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer remembers the last winner.
module rr_arb2
    import onchip_mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    port_id_t last_q;

    // Grant the lone requester, or on contention the port that lost last time.
    always_comb begin
        // NOTE: assign a default first so every path drives gnt and no latch is inferred.
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last_q == P0) ? 2'b10 : 2'b01;
        end
    end

    // Remember the most recent winner; resetting to P1 makes P0 preferred first.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset_n) begin
            last_q <= P1;
        end else if (|gnt) begin
            last_q <= gnt[1] ? P1 : P0;
        end
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Two-port Avalon-MM arbiter in front of a single-port, 1-cycle-latency memory.
module onchip_mem_arbiter
    import onchip_mem_arbiter_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   p0_address,
    input  logic                p0_read,
    input  logic                p0_write,
    input  logic [DATA_W/8-1:0] p0_byteenable,
    input  logic [DATA_W-1:0]   p0_writedata,
    output logic                p0_waitrequest,
    output logic [DATA_W-1:0]   p0_readdata,
    output logic                p0_readdatavalid,
    output logic                p0_oor_err,
    input  logic [ADDR_W-1:0]   p1_address,
    input  logic                p1_read,
    input  logic                p1_write,
    input  logic [DATA_W/8-1:0] p1_byteenable,
    input  logic [DATA_W-1:0]   p1_writedata,
    output logic                p1_waitrequest,
    output logic [DATA_W-1:0]   p1_readdata,
    output logic                p1_readdatavalid,
    output logic                p1_oor_err,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    // One extra bit so a DEPTH equal to 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    logic [1:0]          req;
    logic [1:0]          gnt;
    logic                grant_any;
    logic                sel_p1;
    logic                sel_write;
    logic                sel_oor;
    logic [ADDR_W-1:0]   sel_address;
    rsp_t                rsp_next;
    rsp_t                rsp_q;
    logic [DATA_W-1:0]   rsp_data;
    logic [DATA_W-1:0]   p0_hold_q;
    logic [DATA_W-1:0]   p1_hold_q;

    // Requests are masked during reset so waitrequest stays high and the memory bus idles.
    assign req = {p1_read | p1_write, p0_read | p0_write} & {2{reset_n}};

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .gnt     (gnt)
    );

    assign grant_any      = |gnt;
    assign sel_p1         = gnt[1];
    assign p0_waitrequest = ~gnt[0];
    assign p1_waitrequest = ~gnt[1];

    // Steer the winning port onto the memory bus in the grant cycle; write beats read.
    always_comb begin
        sel_address    = sel_p1 ? p1_address : p0_address;
        sel_write      = sel_p1 ? p1_write   : p0_write;
        sel_oor        = ({1'b0, sel_address} >= DEPTH_LIM);
        mem_address    = grant_any ? sel_address : '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        if (grant_any) begin
            mem_byteenable = sel_p1 ? p1_byteenable : p0_byteenable;
            mem_writedata  = sel_p1 ? p1_writedata  : p0_writedata;
        end
        mem_write      = grant_any & sel_write;
        mem_chipselect = grant_any & ~sel_oor;
        rsp_next       = '{valid: grant_any & ~sel_write,
                           port:  sel_p1 ? P1 : P0,
                           oor:   sel_oor};
    end

    // Clock enable is permanently on in operation; it drops only so reset shows all-zero outputs.
    assign mem_clken = reset_n;

    // Response register: a granted read returns data exactly one cycle later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_q <= '0;
        end else begin
            rsp_q <= rsp_next;
        end
    end

    assign rsp_data         = rsp_q.oor ? '0 : mem_readdata;
    assign p0_readdatavalid = rsp_q.valid && (rsp_q.port == P0);
    assign p1_readdatavalid = rsp_q.valid && (rsp_q.port == P1);
    assign p0_readdata      = p0_readdatavalid ? rsp_data : p0_hold_q;
    assign p1_readdata      = p1_readdatavalid ? rsp_data : p1_hold_q;

    // Keep each port's last returned word so readdata is stable between responses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p0_hold_q <= '0;
            p1_hold_q <= '0;
        end else begin
            if (p0_readdatavalid) p0_hold_q <= rsp_data;
            if (p1_readdatavalid) p1_hold_q <= rsp_data;
        end
    end

    // Sticky out-of-range flags, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p0_oor_err <= 1'b0;
            p1_oor_err <= 1'b0;
        end else if (grant_any && sel_oor) begin
            if (sel_p1) p1_oor_err <= 1'b1;
            else        p0_oor_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Scoreboard bench for onchip_mem_arbiter with a behavioural 1-cycle memory.
module tb_onchip_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [11:0] p0_address, p1_address, mem_address;
    logic        p0_read, p0_write, p1_read, p1_write;
    logic [3:0]  p0_byteenable, p1_byteenable, mem_byteenable;
    logic [31:0] p0_writedata, p1_writedata, mem_writedata;
    logic        p0_waitrequest, p1_waitrequest;
    logic [31:0] p0_readdata, p1_readdata, mem_readdata;
    logic        p0_readdatavalid, p1_readdatavalid, p0_oor_err, p1_oor_err;
    logic        mem_chipselect, mem_write, mem_clken;

    typedef struct {
        logic        port;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_model[int];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    onchip_mem_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .p0_address(p0_address), .p0_read(p0_read), .p0_write(p0_write),
        .p0_byteenable(p0_byteenable), .p0_writedata(p0_writedata),
        .p0_waitrequest(p0_waitrequest), .p0_readdata(p0_readdata),
        .p0_readdatavalid(p0_readdatavalid), .p0_oor_err(p0_oor_err),
        .p1_address(p1_address), .p1_read(p1_read), .p1_write(p1_write),
        .p1_byteenable(p1_byteenable), .p1_writedata(p1_writedata),
        .p1_waitrequest(p1_waitrequest), .p1_readdata(p1_readdata),
        .p1_readdatavalid(p1_readdatavalid), .p1_oor_err(p1_oor_err),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Untouched words read as 0x1000_0000 + address so read data is predictable.
    function automatic logic [31:0] mem_peek(input int a);
        return mem_model.exists(a) ? mem_model[a] : 32'h1000_0000 + 32'(a);
    endfunction

    // Behavioural single-port memory: byte-masked write, registered read.
    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                logic [31:0] w;
                w = mem_peek(int'(mem_address));
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) w[8*b +: 8] = mem_writedata[8*b +: 8];
                mem_model[int'(mem_address)] = w;
            end else begin
                mem_readdata <= mem_peek(int'(mem_address));
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else             n_pass++;
    endtask

    // Monitor: every readdatavalid must match the oldest expected response, on the right cycle.
    always @(negedge clk) begin
        if (p0_readdatavalid && p1_readdatavalid) begin
            check("both_valid", 32'd1, 32'd0);
        end else if (p0_readdatavalid || p1_readdatavalid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", {31'd0, p1_readdatavalid}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_port", {31'd0, p1_readdatavalid}, {31'd0, e.port});
                check("rsp_data", p1_readdatavalid ? p1_readdata : p0_readdata, e.data);
                check("rsp_lag", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic drive_idle();
        p0_read = 0; p0_write = 0; p0_address = '0; p0_byteenable = '0; p0_writedata = '0;
        p1_read = 0; p1_write = 0; p1_address = '0; p1_byteenable = '0; p1_writedata = '0;
    endtask

    task automatic idle(input int n);
        drive_idle();
        repeat (n) @(negedge clk);
    endtask

    // One request cycle: drive, check the combinational grant, queue any read response.
    task automatic issue(input string name, input logic [1:0] rd, input logic [1:0] wr,
                         input logic [11:0] a0, input logic [11:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [3:0] be0, input logic [3:0] be1,
                         input logic [1:0] exp_gnt, input logic exp_cs,
                         input logic exp_rsp, input logic [31:0] exp_data);
        logic [1:0] exp_wait;
        exp_t       e;
        exp_wait = ~exp_gnt;
        p0_read = rd[0]; p0_write = wr[0]; p0_address = a0; p0_writedata = d0; p0_byteenable = be0;
        p1_read = rd[1]; p1_write = wr[1]; p1_address = a1; p1_writedata = d1; p1_byteenable = be1;
        #1;
        check({name, "_wait"}, {30'd0, p1_waitrequest, p0_waitrequest}, {30'd0, exp_wait});
        check({name, "_cs"}, {31'd0, mem_chipselect}, {31'd0, exp_cs});
        if (exp_gnt != 2'b00) begin
            check({name, "_addr"}, {20'd0, mem_address}, {20'd0, exp_gnt[1] ? a1 : a0});
            check({name, "_we"}, {31'd0, mem_write}, {31'd0, exp_gnt[1] ? wr[1] : wr[0]});
            if (exp_gnt[1] ? wr[1] : wr[0]) begin
                check({name, "_wdata"}, mem_writedata, exp_gnt[1] ? d1 : d0);
                check({name, "_be"}, {28'd0, mem_byteenable}, {28'd0, exp_gnt[1] ? be1 : be0});
            end
        end
        if (exp_rsp) begin
            e.port = exp_gnt[1];
            e.data = exp_data;
            e.cyc  = cyc + 1;
            exp_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_wait"}, {30'd0, p1_waitrequest, p0_waitrequest}, 32'd3);
        check({name, "_rdv"}, {30'd0, p1_readdatavalid, p0_readdatavalid}, 32'd0);
        check({name, "_rd0"}, p0_readdata, 32'd0);
        check({name, "_rd1"}, p1_readdata, 32'd0);
        check({name, "_oor"}, {30'd0, p1_oor_err, p0_oor_err}, 32'd0);
        check({name, "_mem"}, {20'd0, mem_address} | {28'd0, mem_byteenable} | mem_writedata, 32'd0);
        check({name, "_ctl"}, {29'd0, mem_chipselect, mem_write, mem_clken}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        drive_idle();
        // Requests during reset must be masked, including an out-of-range write.
        p0_read = 1; p1_write = 1; p1_address = 12'hFFF;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        drive_idle();
        reset_n = 1'b1;

        // Both ports read continuously from reset: grants alternate starting with p0.
        for (int i = 0; i < 6; i++) begin
            logic [11:0] a0, a1;
            a0 = 12'h100 + 12'(i);
            a1 = 12'h200 + 12'(i);
            issue("rr_alt", 2'b11, 2'b00, a0, a1, '0, '0, 4'hF, 4'hF,
                  (i % 2 == 0) ? 2'b01 : 2'b10, 1'b1, 1'b1,
                  (i % 2 == 0) ? 32'h1000_0000 + 32'(a0) : 32'h1000_0000 + 32'(a1));
        end
        idle(2);

        // p0 full-word write then read back.
        issue("p0_wr", 2'b00, 2'b01, 12'h010, '0, 32'hA5A5_1234, '0, 4'hF, 4'h0, 2'b01, 1'b1, 1'b0, '0);
        issue("p0_rd", 2'b01, 2'b00, 12'h010, '0, '0, '0, 4'hF, 4'h0, 2'b01, 1'b1, 1'b1, 32'hA5A5_1234);
        idle(3);
        check("p0_hold", p0_readdata, 32'hA5A5_1234);
        check("p0_hold_v", {31'd0, p0_readdatavalid}, 32'd0);

        // p1 partial write over an all-ones word.
        issue("p1_wr_ff", 2'b00, 2'b10, '0, 12'h020, '0, 32'hFFFF_FFFF, 4'h0, 4'hF, 2'b10, 1'b1, 1'b0, '0);
        issue("p1_wr_be", 2'b00, 2'b10, '0, 12'h020, '0, 32'h1122_3344, 4'h0, 4'h3, 2'b10, 1'b1, 1'b0, '0);
        issue("p1_rd_be", 2'b10, 2'b00, '0, 12'h020, '0, '0, 4'h0, 4'hF, 2'b10, 1'b1, 1'b1, 32'hFFFF_3344);
        idle(2);

        // Pointer follows single grants too: p0, p1 alone, then contention goes to p0.
        issue("ptr_a", 2'b11, 2'b00, 12'h030, 12'h031, '0, '0, 4'hF, 4'hF, 2'b01, 1'b1, 1'b1, 32'h1000_0030);
        issue("ptr_b", 2'b10, 2'b00, 12'h030, 12'h032, '0, '0, 4'hF, 4'hF, 2'b10, 1'b1, 1'b1, 32'h1000_0032);
        issue("ptr_c", 2'b11, 2'b00, 12'h033, 12'h034, '0, '0, 4'hF, 4'hF, 2'b01, 1'b1, 1'b1, 32'h1000_0033);
        issue("ptr_d", 2'b01, 2'b00, 12'h035, 12'h034, '0, '0, 4'hF, 4'hF, 2'b01, 1'b1, 1'b1, 32'h1000_0035);
        issue("ptr_e", 2'b11, 2'b00, 12'h036, 12'h037, '0, '0, 4'hF, 4'hF, 2'b10, 1'b1, 1'b1, 32'h1000_0037);
        idle(2);

        // Read and write together: the write wins and no response is produced.
        issue("rw_both", 2'b01, 2'b01, 12'h005, '0, 32'h0000_00FF, '0, 4'hF, 4'h0, 2'b01, 1'b1, 1'b0, '0);
        idle(1);
        issue("rw_rd", 2'b01, 2'b00, 12'h005, '0, '0, '0, 4'hF, 4'h0, 2'b01, 1'b1, 1'b1, 32'h0000_00FF);
        idle(2);

        // Out-of-range: first address past the end, then the last valid word.
        issue("oor_rd", 2'b10, 2'b00, '0, 12'hA00, '0, '0, 4'h0, 4'hF, 2'b10, 1'b0, 1'b1, 32'h0);
        idle(1);
        check("oor_flag_p1", {30'd0, p1_oor_err, p0_oor_err}, 32'd2);
        issue("edge_rd", 2'b10, 2'b00, '0, 12'h9FF, '0, '0, 4'h0, 4'hF, 2'b10, 1'b1, 1'b1, 32'h1000_09FF);
        issue("oor_wr", 2'b00, 2'b01, 12'hFFF, '0, 32'hDEAD_BEEF, '0, 4'hF, 4'h0, 2'b01, 1'b0, 1'b0, '0);
        idle(4);
        check("oor_flag_both", {30'd0, p1_oor_err, p0_oor_err}, 32'd3);

        // Reset arriving just after a read grant must discard the response.
        p0_read = 1; p0_address = 12'h010; p0_byteenable = 4'hF;
        #1;
        check("pre_rst_gnt", {31'd0, p0_waitrequest}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        drive_idle();
        #1;
        check_reset_outputs("mid_rst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        idle(4);
        check("post_rst_oor", {30'd0, p1_oor_err, p0_oor_err}, 32'd0);
        check("post_rst_rd0", p0_readdata, 32'd0);
        issue("post_rst_rd", 2'b01, 2'b00, 12'h010, '0, '0, '0, 4'hF, 4'h0, 2'b01, 1'b1, 1'b1, 32'hA5A5_1234);
        idle(3);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/onchip_mem_arbiter.md
ONCHIP_MEM_ARBITER -- requirements
Module: onchip_mem_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2560: number of 32-bit memory words.
REQ-002 SHALL have parameter ADDR_W, default 12: word-address width.
REQ-003 SHALL have parameter DATA_W, default 32: data width, with byte lanes of 8 bits (DATA_W/8 enables).
REQ-004 clk  in  1  single clock; all logic is rising-edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 p0_address/p1_address  in  ADDR_W  requester word address (p0 = CPU, p1 = DMA/video).
REQ-007 p0_read/p1_read, p0_write/p1_write  in  1  Avalon-MM read and write strobes.
REQ-008 p0_byteenable/p1_byteenable  in  DATA_W/8; p0_writedata/p1_writedata  in  DATA_W.
REQ-009 p0_waitrequest/p1_waitrequest  out  1  low while that port's request is accepted this cycle.
REQ-010 p0_readdata/p1_readdata  out  DATA_W; p0_readdatavalid/p1_readdatavalid  out  1.
REQ-011 p0_oor_err/p1_oor_err  out  1  sticky flag: an out-of-range access was made.
REQ-012 mem_address  out  ADDR_W; mem_byteenable  out  DATA_W/8; mem_writedata  out  DATA_W.
REQ-013 mem_chipselect, mem_write, mem_clken  out  1; mem_readdata  in  DATA_W (memory read latency is 1 cycle).

Function
REQ-014 A port requests when read|write is high; if both strobes are high, write wins and the read is ignored.
REQ-015 Arbitration SHALL be round-robin, with at most one grant per cycle:
- single requester: granted immediately;
- both requesting: grant goes to the port not granted most recently;
- the pointer updates only on a grant.
REQ-016 pX_waitrequest SHALL be combinational and equal to NOT grantX, so it is high when idle or losing arbitration.
REQ-017 On grant, mem_address, mem_byteenable, mem_writedata and mem_write SHALL be driven combinationally from the granted port in the same cycle; mem_clken SHALL be tied to 1.
REQ-018 mem_chipselect SHALL be high only for a granted access with address < DEPTH.
REQ-019 A granted read SHALL be recorded in a 1-deep response register (valid, port id, oor):
- pX_readdatavalid is asserted exactly one cycle after the grant, for one cycle;
- pX_readdata carries mem_readdata, or 0 if oor;
- the other port's readdatavalid stays low.
REQ-020 Back-to-back grants SHALL be sustained every cycle (throughput 1 access/cycle); a response and a new grant may coincide.
REQ-021 A write SHALL complete in its grant cycle and produce no readdatavalid.
REQ-022 Out-of-range access (address >= DEPTH):
- still accepted;
- no memory access;
- a read returns 0;
- a write is dropped;
- pX_oor_err is set and held until reset.
REQ-023 pX_readdata SHALL hold its last value when readdatavalid is low.

Reset
REQ-024 While reset_n is low, all outputs SHALL be 0, except waitrequest, which is 1.
REQ-025 At reset the round-robin pointer SHALL prefer p0 and oor flags SHALL be cleared.
REQ-026 Reset asserted with a read pending SHALL discard the response; no readdatavalid after release.
REQ-027 First grant possible in the first clock edge after reset_n deasserts.

Structure
REQ-028 A shared package SHALL hold DEPTH/ADDR_W/DATA_W defaults, the port-id type (P0, P1), and the response-register record type.
REQ-029 The round-robin selection SHALL be one sub-module, rr_arb2 (2-way request in, one-hot grant out, pointer register).
REQ-030 The top level SHALL contain the muxing, response register and oor flags; no memory instance.

Verification
REQ-031 p0 write addr 0x010 data 0xA5A5_1234 be 0xF, then p0 read 0x010 -> p0_readdatavalid one cycle after grant, readdata 0xA5A5_1234.
REQ-032 p0 and p1 both read continuously for 6 cycles, from reset -> grants alternate p0,p1,p0,p1,p0,p1; each readdatavalid lags its grant by exactly 1.
REQ-033 p1 write 0x020 data 0x1122_3344 with be 0x3 over 0xFFFF_FFFF -> subsequent read returns 0xFFFF_3344.
REQ-034 p1 read address 0xA00 (=2560) -> mem_chipselect low, p1_readdata 0 with valid, p1_oor_err 1 persisting until reset.
REQ-035 p0 read granted, reset_n pulsed low in the following cycle -> no p0_readdatavalid; all outputs at reset values.
REQ-036 p0 read and write asserted together at 0x005 with data 0x0000_00FF -> write performed, no readdatavalid; later read returns 0x0000_00FF.
